// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the two-requester unified memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_D = 2'd1,
    WAIT_I = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // Read data returned to the requester when a transfer is aborted on timeout.
  localparam int TIMEOUT_DATA = 0;

endpackage

// File: rtl/mem_arb_prio.sv
// Grant selection between fetch and data requests, with a saturating counter
// that bounds how many data grants may pass a waiting fetch.
module mem_arb_prio #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic d_req,
  input  logic grant,
  output logic grant_d,
  output logic grant_i
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;

  // Data wins unless the fetch side has already been passed LIMIT times.
  always_comb begin
    grant_d = d_req & (~if_req | (starve_cnt < LIMIT));
    grant_i = if_req & ~grant_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant) begin
      if (grant_i) begin
        starve_cnt <= '0;
      end else if (grant_d && if_req && (starve_cnt < LIMIT)) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Sequences a single-ported variable-latency memory between the IF and MEM
// stages: one grant at a time, done pulse on completion, global stall.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              pipe_stall,
  output logic              bus_err
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0]   TO_LAST    = TO_W'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] ABORT_DATA = DATA_W'(TIMEOUT_DATA);

  arb_state_t      state;
  arb_state_t      state_nxt;
  logic            d_req;
  logic            in_idle;
  logic            in_wait;
  logic            grant_d;
  logic            grant_i;
  logic            to_hit;
  logic            xfer_end;
  logic [TO_W-1:0] to_cnt;

  assign d_req    = d_rd | d_wr;
  assign in_idle  = (state == IDLE);
  assign in_wait  = (state == WAIT_D) || (state == WAIT_I);
  assign to_hit   = (to_cnt == TO_LAST);
  // Memory handshake: mem_req rises with stable addr/we/wdata and stays high,
  // unchanged, until the single-cycle mem_ack (or timeout) ends the transfer;
  // mem_ack while mem_req is low is ignored.
  assign xfer_end = in_wait & (mem_ack | to_hit);

  assign pipe_stall = (if_req & ~if_done) | (d_req & ~d_done);

  mem_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk    (clk),
    .rst    (rst),
    .if_req (if_req),
    .d_req  (d_req),
    .grant  (in_idle),
    .grant_d(grant_d),
    .grant_i(grant_i)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_d) begin
          state_nxt = WAIT_D;
        end else if (grant_i) begin
          state_nxt = WAIT_I;
        end
      end
      WAIT_D, WAIT_I: begin
        if (xfer_end) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (in_wait && !xfer_end) begin
      to_cnt <= to_cnt + TO_W'(1);
    end else begin
      to_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            mem_req   <= 1'b1;
            mem_we    <= d_wr;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
          end else if (grant_i) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
          end
        end
        WAIT_D: begin
          if (xfer_end) begin
            mem_req <= 1'b0;
            d_done  <= 1'b1;
            if (!mem_we) begin
              d_rdata <= mem_ack ? mem_rdata : ABORT_DATA;
            end
            if (!mem_ack) begin
              bus_err <= 1'b1;
            end
          end
        end
        WAIT_I: begin
          if (xfer_end) begin
            mem_req  <= 1'b0;
            if_done  <= 1'b1;
            if_rdata <= mem_ack ? mem_rdata : ABORT_DATA;
            if (!mem_ack) begin
              bus_err <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory responder, requester tasks, reference
// memory model with expected-data queues, and a negedge monitor.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SL = 4;
  localparam int TO = 255;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_done;
  logic          d_rd;
  logic          d_wr;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_done;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          pipe_stall;
  logic          bus_err;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .pipe_stall(pipe_stall), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] if_exp_q[$];
  logic [DW-1:0] d_exp_q[$];
  logic [DW-1:0] mem_arr[logic [AW-1:0]];
  logic [DW-1:0] ref_mem[logic [AW-1:0]];
  logic [DW-1:0] d_last;
  int            fixed_lat      = -1;
  bit            ack_block      = 1'b0;
  bit            spurious_en    = 1'b0;
  bit            expect_timeout = 1'b0;
  bit            exp_bus_err    = 1'b0;
  bit            grant_log[$];
  int            cons;

  bit            p_if_req, p_d_req, p_d_wr, p_mem_req, p_if_done, p_d_done, p_mem_we;
  logic [AW-1:0] p_if_addr, p_d_addr, p_mem_addr;
  logic [DW-1:0] p_d_wdata, p_mem_wdata;

  function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : pattern(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_done(input bit is_d, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    for (int i = 1; i <= 2000; i++) begin
      @(negedge clk);
      n = i;
      if (is_d ? d_done : if_done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check(is_d ? "d_done_timeout" : "if_done_timeout", is_d ? d_done : if_done, 1);
  endtask

  task automatic if_fetch(input logic [AW-1:0] a, output int n);
    if_addr = a;
    if_req  = 1'b1;
    if_exp_q.push_back(ref_read(a));
    wait_done(1'b0, n);
    @(posedge clk);
    #1;
    if_req = 1'b0;
  endtask

  task automatic d_access(input bit we, input bit both, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, output int n);
    logic [DW-1:0] e;
    d_addr  = a;
    d_wdata = wd;
    d_wr    = we;
    d_rd    = !we || both;
    if (we) begin
      e = d_last;
      ref_mem[a] = wd;
    end else if (expect_timeout) begin
      e = '0;
    end else begin
      e = ref_read(a);
    end
    d_last = e;
    d_exp_q.push_back(e);
    wait_done(1'b1, n);
    @(posedge clk);
    #1;
    d_rd = 1'b0;
    d_wr = 1'b0;
  endtask

  // Memory responder: random or fixed latency per request, optional spurious acks.
  initial begin : responder
    int lat;
    bit pending;
    lat = 0;
    pending = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    mem_arr[32'h40] = 32'h8C22_0004;
    forever begin
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = 32'hDEAD_BEEF;
      if (rst) begin
        pending = 1'b0;
      end else if (mem_req) begin
        if (!pending) begin
          pending = 1'b1;
          lat = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 3);
        end
        if (!ack_block) begin
          if (lat == 0) begin
            mem_ack = 1'b1;
            pending = 1'b0;
            if (mem_we) mem_arr[mem_addr] = mem_wdata;
            else mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : pattern(mem_addr);
          end else begin
            lat--;
          end
        end
      end else begin
        pending = 1'b0;
        if (spurious_en && $urandom_range(0, 5) == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = $urandom;
        end
      end
    end
  end

  initial begin : monitor
    bit act_d, exp_d, exp_stall;
    cons = 0;
    p_mem_req = 0; p_if_done = 0; p_d_done = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cons = 0;
        p_mem_req = 0; p_if_done = 0; p_d_done = 0;
      end else begin
        if (mem_req && !p_mem_req) begin
          act_d = mem_addr[8];
          exp_d = p_d_req && (!p_if_req || cons < SL);
          check("grant_is_data", act_d, exp_d);
          grant_log.push_back(act_d);
          if (exp_d) begin
            check("grant_d_addr", mem_addr, p_d_addr);
            check("grant_d_we", mem_we, p_d_wr);
            if (p_d_wr) check("grant_wdata", mem_wdata, p_d_wdata);
            if (p_if_req && cons < SL) cons++;
          end else begin
            check("grant_i_addr", mem_addr, p_if_addr);
            check("grant_i_we", mem_we, 0);
            cons = 0;
          end
        end
        if (mem_req && p_mem_req) begin
          check("hold_addr", mem_addr, p_mem_addr);
          check("hold_we", mem_we, p_mem_we);
          check("hold_wdata", mem_wdata, p_mem_wdata);
        end
        if (if_done) begin
          check("if_done_single", p_if_done, 0);
          if (if_exp_q.size() == 0) check("if_done_unexpected", if_done, 0);
          else begin
            check("if_rdata", if_rdata, if_exp_q.pop_front());
            check("if_bus_err", bus_err, exp_bus_err);
          end
        end
        if (d_done) begin
          check("d_done_single", p_d_done, 0);
          if (d_exp_q.size() == 0) check("d_done_unexpected", d_done, 0);
          else begin
            check("d_rdata", d_rdata, d_exp_q.pop_front());
            check("d_bus_err", bus_err, exp_bus_err);
          end
        end
        if (if_done && d_done) check("done_exclusive", d_done, 0);
        exp_stall = (if_req && !if_done) || ((d_rd || d_wr) && !d_done);
        check("pipe_stall", pipe_stall, exp_stall);
        p_mem_req = mem_req; p_if_done = if_done; p_d_done = d_done;
      end
      p_if_req = if_req; p_d_req = d_rd | d_wr; p_d_wr = d_wr;
      p_if_addr = if_addr; p_d_addr = d_addr; p_d_wdata = d_wdata;
      p_mem_addr = mem_addr; p_mem_we = mem_we; p_mem_wdata = mem_wdata;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n, cnt, g0;
    rst = 1'b1;
    if_req = 0; if_addr = '0; d_rd = 0; d_wr = 0; d_addr = '0; d_wdata = '0;
    d_last = '0;
    ref_mem[32'h40] = 32'h8C22_0004;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_if_done", if_done, 0);
    check("rst_d_done", d_done, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Fetch with ack two cycles after mem_req.
    fixed_lat = 2;
    if_fetch(32'h40, n);
    check("if_latency", n - 1, 4);

    // Load, store with immediate ack, then read back.
    fixed_lat = 0;
    d_access(1'b0, 1'b0, 32'h104, '0, n);
    check("load_latency", n - 1, 2);
    d_access(1'b1, 1'b0, 32'h100, 32'hCAFE_F00D, n);
    check("store_latency", n - 1, 2);
    d_access(1'b0, 1'b0, 32'h100, '0, n);

    // Spurious acks with no requests pending.
    spurious_en = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (mem_req) cnt++;
    end
    check("spurious_mem_req", cnt, 0);
    spurious_en = 1'b0;
    @(posedge clk);
    #1;

    // Both requesters held: four data grants then one fetch, repeating.
    fixed_lat = -1;
    g0 = grant_log.size();
    fork
      begin
        int l;
        repeat (2) if_fetch(AW'($urandom_range(0, 63) << 2), l);
      end
      begin
        int l;
        repeat (8) d_access(1'b0, 1'b0, 32'h100 + AW'($urandom_range(0, 63) << 2), '0, l);
      end
    join
    check("starve_grant_count", grant_log.size() - g0, 10);
    for (int i = 0; i < 10; i++) begin
      if (g0 + i < grant_log.size()) check("starve_seq", grant_log[g0 + i], (i % 5) != 4);
    end

    // Load with no ack: aborted after TIMEOUT cycles, sticky bus_err.
    check("bus_err_pre", bus_err, 0);
    ack_block = 1'b1;
    expect_timeout = 1'b1;
    exp_bus_err = 1'b1;
    fork
      d_access(1'b0, 1'b0, 32'h1F0, '0, n);
      begin
        int c;
        for (int w = 0; w < 20 && !mem_req; w++) @(negedge clk);
        c = 0;
        while (mem_req && c < 400) begin
          @(negedge clk);
          c++;
        end
        check("timeout_cycles", c, TO);
      end
    join
    ack_block = 1'b0;
    expect_timeout = 1'b0;
    check("bus_err_set", bus_err, 1);

    // Random mixed traffic with spurious acks between transfers.
    spurious_en = 1'b1;
    fork
      begin
        int l, gap;
        repeat (30) begin
          if_fetch(AW'($urandom_range(0, 63) << 2), l);
          gap = $urandom_range(0, 2);
          if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
          end
        end
      end
      begin
        int l, gap;
        bit we;
        repeat (30) begin
          we = ($urandom_range(0, 1) == 1);
          d_access(we, ($urandom_range(0, 3) == 0), 32'h100 + AW'($urandom_range(0, 63) << 2),
                   $urandom, l);
          gap = $urandom_range(0, 2);
          if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
          end
        end
      end
    join
    spurious_en = 1'b0;
    check("bus_err_sticky", bus_err, 1);

    // Asynchronous reset in the middle of a fetch wait.
    fixed_lat = 6;
    if_addr = 32'h80;
    if_req = 1'b1;
    for (int w = 0; w < 20 && !mem_req; w++) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_mem_req", mem_req, 0);
    check("arst_mem_we", mem_we, 0);
    check("arst_mem_addr", mem_addr, 0);
    check("arst_mem_wdata", mem_wdata, 0);
    check("arst_if_rdata", if_rdata, 0);
    check("arst_d_rdata", d_rdata, 0);
    check("arst_if_done", if_done, 0);
    check("arst_d_done", d_done, 0);
    check("arst_bus_err", bus_err, 0);
    exp_bus_err = 1'b0;
    d_last = '0;
    @(negedge clk);
    #1 rst = 1'b0;
    if_exp_q.push_back(ref_read(32'h80));
    wait_done(1'b0, n);
    @(posedge clk);
    #1;
    if_req = 1'b0;

    repeat (5) @(negedge clk);
    check("if_q_empty", if_exp_q.size(), 0);
    check("d_q_empty", d_exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
